ospi_flash_core: RTL and testbench
==================================

// Module: ospi_flash_core
// PURPOSE
//  Parametrised NOR-flash array model behind the OSPI flash front end: one valid/ready request port for read, program,
//  sector erase and chip erase, with multi-cycle program and erase timing, a busy flag and error reporting.
//  It replaces the fixed 8-bit array inside ospi_flash. It has real flash semantics: program clears bits only, erase sets words to all-ones.
// PARAMETERS
//  DATA_W      8   word width in bits
//  ADDR_W      8   word address width; array depth is 2**ADDR_W
//  SECTOR_W    4   log2 of words per sector; NUM_SECT = 2**(ADDR_W-SECTOR_W)
//  PROG_CYCLES 4   busy cycles per program operation (>=1)
// PORTS
//  clk        in   1         single clock; everything is posedge clk
//  reset_n    in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         block idle, request can be accepted
//  req_op     in   2         00 read, 01 program, 10 sector erase, 11 chip erase
//  req_addr   in   ADDR_W    word address; for sector erase, selects sector req_addr[ADDR_W-1:SECTOR_W]
//  req_wdata  in   DATA_W    program data
//  rsp_valid  out  1         one-cycle response pulse; no backpressure
//  rsp_rdata  out  DATA_W    read data; 0 for non-read ops
//  rsp_err    out  1         error flag, valid with rsp_valid
//  busy       out  1         high whenever state != IDLE
// BEHAVIOUR
//  - Reset: req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state IDLE, counters 0.
//  - Array is non-volatile: it is initialised to all-ones at time zero and is never touched by reset.
//  - FSM states: IDLE, READ, PROG, ERASE, RESP. req_ready = (state==IDLE).
//  - Accept on edge k when req_valid && req_ready; addr, op and wdata are captured at acceptance.
//  - Latency L: rsp_valid is high from edge k+L to edge k+L+1. The block returns to IDLE at edge k+L+1.
//  - Read: IDLE->READ->RESP, L=2. rsp_rdata = mem[addr].
//  - Program: IDLE->PROG, held for PROG_CYCLES cycles, then RESP; L=PROG_CYCLES+1.
//    mem[addr] <= mem[addr] & wdata, committed on the last PROG cycle.
//    rsp_err=1 if (~mem[addr] & wdata) != 0, i.e. an attempted 0->1; the AND result is still stored.
//  - Sector erase: the walk counter steps through the sector, writing all-ones to one word per cycle.
//    2**SECTOR_W ERASE cycles; L=2**SECTOR_W+1.
//  - Chip erase: same walk over the whole array; L=2**ADDR_W+1.
//  - Walk counter is ADDR_W bits; it starts at the sector base (or 0) and stops at the last word, with no wrap into the next sector.
//  - No request is accepted while busy, so read-during-program is not possible. rsp_valid and req_ready are never high together.
//  - Reset mid-operation:
//    - FSM goes to IDLE immediately and no response is issued.
//    - An uncommitted program is discarded.
//    - Erase leaves already-walked words at all-ones and the rest unchanged.
// CONFIGURATION
//  OSPI_FLASH_WP_EN defined:
//   - Adds input wp_mask[NUM_SECT-1:0].
//   - Program or sector erase targeting a sector with its bit set: IDLE->RESP, L=1, rsp_err=1, array unchanged.
//   - Chip erase with any wp_mask bit set: same rejection.
//   - wp_mask is sampled at acceptance only. Reads are never blocked.
//  OSPI_FLASH_WP_EN undefined: port absent; nothing is ever protected.
// TESTING (defaults: DATA_W=8, ADDR_W=8, SECTOR_W=4, PROG_CYCLES=4)
//  1. Reset, read 0x01 -> rsp_valid at k+2, rsp_rdata=0xFF, rsp_err=0; req_ready low for edges k+1..k+2.
//  2. Program 0x01 with 0xA5 -> busy for 5 cycles, rsp_valid at k+5, rsp_err=0; read 0x01 -> 0xA5.
//  3. Program 0x01 with 0x5A over 0xA5 -> rsp_err=1; read 0x01 -> 0x00.
//  4. Sector erase, addr 0x03, after programming 0x00 and 0x10 -> rsp_valid at k+17; 0x00..0x0F=0xFF, 0x10 unchanged.
//  5. reset_n low 5 cycles into a sector-0 erase -> outputs at reset values at once.
//     Words 0x00..0x04=0xFF, rest unchanged; new read accepted after release.
//  6. OSPI_FLASH_WP_EN, wp_mask[0]=1, program 0x02 with 0x00 -> rsp_valid at k+1, rsp_err=1; read 0x02 -> 0xFF.

Source files
------------

// File: rtl/ospi_flash_core.sv
// NOR-flash array model: read / program / sector erase / chip erase behind one valid/ready port.
// Optional write protection via OSPI_FLASH_WP_EN (adds wp_mask, one bit per sector).
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  S_IDLE  | ready for a request
//  S_READ  | one cycle fetching mem[addr] into the response register
//  S_PROG  | PROG_CYCLES busy cycles; AND-commit on the last one
//  S_ERASE | walk counter writes all-ones, one word per cycle, up to walk_end
//  S_RESP  | rsp_valid high for one cycle, then back to idle
module ospi_flash_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [1:0]                          req_op,
    input  logic [ADDR_W-1:0]                   req_addr,
    input  logic [DATA_W-1:0]                   req_wdata,
`ifdef OSPI_FLASH_WP_EN
    input  logic [2**(ADDR_W-SECTOR_W)-1:0]     wp_mask,
`endif
    output logic                                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                rsp_err,
    output logic                                busy
);

    localparam int DEPTH      = 2**ADDR_W;
    localparam int SECT_IDX_W = (ADDR_W > SECTOR_W) ? (ADDR_W - SECTOR_W) : 1;
    localparam int CNT_W      = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] SECT_MASK = ADDR_W'((2**SECTOR_W) - 1);
    localparam logic [CNT_W-1:0]  PROG_LOAD = CNT_W'(PROG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_PROG,
        S_ERASE,
        S_RESP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W-1:0]   walk;
    logic [ADDR_W-1:0]   walk_end;
    logic [CNT_W-1:0]    prog_cnt;

    // Non-volatile contents: all-ones at time zero, never touched by reset.
    logic [DATA_W-1:0]   mem [DEPTH] = '{default: '1};

    logic [DATA_W-1:0]   cur_word;
    logic [DATA_W-1:0]   prog_result;
    logic                prog_err;
    logic                prog_last;
    logic                protect;

    assign cur_word    = mem[addr_q];
    assign prog_result = cur_word & wdata_q;
    assign prog_err    = |(~cur_word & wdata_q);
    assign prog_last   = (state == S_PROG) && (prog_cnt == '0);

`ifdef OSPI_FLASH_WP_EN
    logic [SECT_IDX_W-1:0] req_sect;
    assign req_sect = SECT_IDX_W'(req_addr >> SECTOR_W);

    always_comb begin
        protect = 1'b0;
        case (req_op)
            2'b01, 2'b10: protect = wp_mask[req_sect];
            2'b11:        protect = |wp_mask;
            default:      protect = 1'b0;
        endcase
    end
`else
    assign protect = 1'b0;
`endif

    // State is forced to IDLE by reset, so no write can land while reset_n is low.
    always_ff @(posedge clk) begin
        if (prog_last) begin
            mem[addr_q] <= prog_result;
        end else if (state == S_ERASE) begin
            mem[walk] <= '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            walk      <= '0;
            walk_end  <= '0;
            prog_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (protect) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            case (req_op)
                                2'b00: state <= S_READ;
                                2'b01: begin
                                    state    <= S_PROG;
                                    prog_cnt <= PROG_LOAD;
                                end
                                2'b10: begin
                                    state    <= S_ERASE;
                                    walk     <= req_addr & ~SECT_MASK;
                                    walk_end <= req_addr | SECT_MASK;
                                end
                                default: begin
                                    state    <= S_ERASE;
                                    walk     <= '0;
                                    walk_end <= '1;
                                end
                            endcase
                        end
                    end
                end
                S_READ: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cur_word;
                    rsp_err   <= 1'b0;
                end
                S_PROG: begin
                    if (prog_cnt == '0) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= prog_err;
                    end else begin
                        prog_cnt <= prog_cnt - 1'b1;
                    end
                end
                S_ERASE: begin
                    if (walk == walk_end) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                    end else begin
                        walk <= walk + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ospi_flash_core.sv
// Scoreboard bench for ospi_flash_core: directed requests push expected responses,
// a negedge monitor pops and compares data, error flag and latency.
module tb_ospi_flash_core;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_PG = 2'b01;
    localparam logic [1:0] OP_SE = 2'b10;
    localparam logic [1:0] OP_CE = 2'b11;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
`ifdef OSPI_FLASH_WP_EN
    logic [15:0] wp_mask = 16'h0000;
`endif

    ospi_flash_core #(
        .DATA_W(8), .ADDR_W(8), .SECTOR_W(4), .PROG_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef OSPI_FLASH_WP_EN
        .wp_mask   (wp_mask),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         due;
    } exp_t;

    exp_t sb[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_latency", 32'(cyc + 1), 32'(e.due));
                check("ready_low_during_rsp", 32'(req_ready), 32'd0);
            end
        end
    end

    // Returns #1 after the accepting edge; edge index k is the value of cyc then.
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         input bit expect_rsp, input logic [7:0] exp_rdata, input logic exp_err,
                         input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (expect_rsp) begin
            exp_t e;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.due   = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        issue(OP_RD, addr, 8'h00, 1'b1, exp, 1'b0, 2);
    endtask

    task automatic pg(input logic [7:0] addr, input logic [7:0] wdata, input logic exp_err);
        issue(OP_PG, addr, wdata, 1'b1, 8'h00, exp_err, 5);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, busy}), 32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [2:0] rdy;
        int b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_outputs("reset_values");

        // Read of erased array, with req_ready low while busy
        rd(8'h01, 8'hFF);
        @(negedge clk); rdy[2] = req_ready;
        @(negedge clk); rdy[1] = req_ready;
        @(negedge clk); rdy[0] = req_ready;
        check("read_ready_pattern", 32'(rdy), 32'(3'b001));
        wait_idle();

        // Program onto erased word, busy for PROG_CYCLES+1
        pg(8'h01, 8'hA5, 1'b0);
        b = 0;
        @(negedge clk);
        while (busy && b < 100) begin
            b++;
            @(negedge clk);
        end
        check("prog_busy_cycles", 32'(b), 32'd5);
        rd(8'h01, 8'hA5);

        // Attempted 0->1 flags an error but stores the AND
        pg(8'h01, 8'h5A, 1'b1);
        rd(8'h01, 8'h00);

        // Sector erase clears sector 0 only
        pg(8'h00, 8'h12, 1'b0);
        pg(8'h10, 8'h34, 1'b0);
        issue(OP_SE, 8'h03, 8'h00, 1'b1, 8'h00, 1'b0, 17);
        rd(8'h00, 8'hFF);
        rd(8'h01, 8'hFF);
        rd(8'h0F, 8'hFF);
        rd(8'h10, 8'h34);

        // Reset five cycles into a sector-0 erase
        pg(8'h04, 8'h11, 1'b0);
        pg(8'h05, 8'h22, 1'b0);
        pg(8'h0F, 8'h33, 1'b0);
        issue(OP_SE, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_erase");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(8'h04, 8'hFF);
        rd(8'h00, 8'hFF);
        rd(8'h05, 8'h22);
        rd(8'h0F, 8'h33);

`ifdef OSPI_FLASH_WP_EN
        // Protected sector rejects program and erase; reads still pass
        wp_mask = 16'h0001;
        issue(OP_PG, 8'h02, 8'h00, 1'b1, 8'h00, 1'b1, 1);
        rd(8'h02, 8'hFF);
        issue(OP_SE, 8'h05, 8'h00, 1'b1, 8'h00, 1'b1, 1);
        rd(8'h05, 8'h22);
        wp_mask = 16'h8000;
        issue(OP_CE, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1);
        rd(8'h10, 8'h34);
        wp_mask = 16'h0000;
`endif

        // Chip erase walks the whole array including the last word
        pg(8'hFF, 8'h00, 1'b0);
        issue(OP_CE, 8'h77, 8'h00, 1'b1, 8'h00, 1'b0, 257);
        rd(8'h10, 8'hFF);
        rd(8'h05, 8'hFF);
        rd(8'hFF, 8'hFF);

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
